// File: rtl/riscv_wb.sv
// riscv_wb: RISC-V writeback stage and register scoreboard.
//   Formats load data at enqueue, buffers results in a 2-entry FIFO and
//   drives a registered register-file write port. Tracks per-register busy bits.
// Latency: a result accepted at edge N (FIFO empty, wb_ready high) writes back after edge N+1.
// Backpressure: in_ready = (count != 2), with no pass-through when full; dequeue gated by wb_ready.
// Ports:
//   issue_valid/issue_rd            - decode issue, sets busy[issue_rd]
//   in_valid/in_ready/in_*          - result handshake from execute/memory
//   wb_ready/wb_en/wb_rd/wb_data    - register-file write port (outputs registered)
//   exc                             - one-cycle pulse when a faulted entry retires
//   busy                            - scoreboard bitmap; retired - committed write count
module riscv_wb #(
  parameter int XLEN = 32,
  parameter int REGA = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [REGA-1:0]      issue_rd,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REGA-1:0]      in_rd,
  input  logic [XLEN-1:0]      in_result,
  input  logic                 in_is_load,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic                 wb_ready,
  output logic                 wb_en,
  output logic [REGA-1:0]      wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 exc,
  output logic [2**REGA-1:0]   busy,
  output logic [XLEN-1:0]      retired
);

  localparam int NREG = 2**REGA;

  // FIFO storage and control
  logic [REGA-1:0] r_fifo_rd    [0:1];
  logic [XLEN-1:0] r_fifo_data  [0:1];
  logic            r_fifo_fault [0:1];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;

  // Registered outputs
  logic            r_wb_en;
  logic [REGA-1:0] r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_exc;
  logic [NREG-1:0] r_busy;
  logic [XLEN-1:0] r_retired;

  logic            w_enq;
  logic            w_deq;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_fmt_data;
  logic            w_fmt_fault;
  logic [REGA-1:0] w_head_rd;
  logic            w_head_fault;
  logic            w_head_writes;
  logic [NREG-1:0] w_busy_set;
  logic [NREG-1:0] w_busy_clr;
  logic [NREG-1:0] w_busy_next;

  assign in_ready = (r_count != 2'd2);
  assign w_enq    = in_valid && in_ready;
  assign w_deq    = (r_count != 2'd0) && wb_ready;

  assign w_head_rd     = r_fifo_rd[r_rptr];
  assign w_head_fault  = r_fifo_fault[r_rptr];
  // Faulted entries and x0 retire without a register write.
  assign w_head_writes = (w_head_rd != '0) && !w_head_fault;

  // Byte and halfword lanes selected by the low address bits.
  always_comb begin
    w_byte = in_result[7:0];
    case (in_addr_lo)
      2'd0:    w_byte = in_result[7:0];
      2'd1:    w_byte = in_result[15:8];
      2'd2:    w_byte = in_result[23:16];
      default: w_byte = in_result[31:24];
    endcase
    w_half = in_addr_lo[1] ? in_result[31:16] : in_result[15:0];
  end

  // Load formatting and alignment fault detection at enqueue.
  always_comb begin
    w_fmt_data  = in_result;
    w_fmt_fault = 1'b0;
    if (in_is_load) begin
      case (in_funct3)
        3'b000: w_fmt_data = {{(XLEN-8){w_byte[7]}}, w_byte};
        3'b100: w_fmt_data = {{(XLEN-8){1'b0}}, w_byte};
        3'b001: begin
          w_fmt_data  = {{(XLEN-16){w_half[15]}}, w_half};
          w_fmt_fault = in_addr_lo[0];
        end
        3'b101: begin
          w_fmt_data  = {{(XLEN-16){1'b0}}, w_half};
          w_fmt_fault = in_addr_lo[0];
        end
        3'b010: w_fmt_fault = (in_addr_lo != 2'd0);
        default: w_fmt_fault = 1'b1;
      endcase
    end
  end

  // Scoreboard: clear on retirement, then set on issue so a same-edge
  // issue to the retiring register keeps it busy. x0 is never busy.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (issue_valid && (issue_rd != '0)) w_busy_set = NREG'(1) << issue_rd;
    if (w_deq)                           w_busy_clr = NREG'(1) << w_head_rd;
    w_busy_next    = (r_busy & ~w_busy_clr) | w_busy_set;
    w_busy_next[0] = 1'b0;
  end

  // FIFO pointers, count and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= 2'd0;
      r_fifo_rd[0]    <= '0;
      r_fifo_rd[1]    <= '0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_fault[0] <= 1'b0;
      r_fifo_fault[1] <= 1'b0;
    end else begin
      if (w_enq) begin
        r_fifo_rd[r_wptr]    <= in_rd;
        r_fifo_data[r_wptr]  <= w_fmt_data;
        r_fifo_fault[r_wptr] <= w_fmt_fault;
        r_wptr               <= ~r_wptr;
      end
      if (w_deq) r_rptr <= ~r_rptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Retirement: registered write port, exception pulse, scoreboard, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_exc     <= 1'b0;
      r_busy    <= '0;
      r_retired <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_deq) begin
        r_wb_rd   <= w_head_rd;
        r_wb_data <= r_fifo_data[r_rptr];
        r_wb_en   <= w_head_writes;
        r_exc     <= w_head_fault;
        if (w_head_writes) r_retired <= r_retired + XLEN'(1);
      end else begin
        r_wb_en <= 1'b0;
        r_exc   <= 1'b0;
      end
    end
  end

  assign wb_en   = r_wb_en;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;
  assign exc     = r_exc;
  assign busy    = r_busy;
  assign retired = r_retired;

endmodule

// File: tb/tb_riscv_wb.sv
// tb_riscv_wb: directed plus randomized checks of riscv_wb against a
//   queue-based reference model of the writeback stage and scoreboard.
module tb_riscv_wb;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        wb_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc;
  logic [31:0] busy;
  logic [31:0] retired;

  riscv_wb #(.XLEN(32), .REGA(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_result(in_result), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .wb_ready(wb_ready), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc(exc), .busy(busy), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int unsigned rd;
    int unsigned data;
    bit          fault;
  } m_entry_t;

  m_entry_t    mq[$];
  bit [31:0]   m_busy;
  bit          m_wb_en;
  int unsigned m_wb_rd;
  int unsigned m_wb_data;
  bit          m_exc;
  int unsigned m_retired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of a load result, computed arithmetically.
  function automatic m_entry_t fmt(int unsigned rd, int unsigned res, bit is_load,
                                   int unsigned f3, int unsigned off);
    m_entry_t    e;
    int unsigned v;
    e.rd = rd; e.data = res; e.fault = 1'b0;
    if (is_load) begin
      case (f3)
        0, 4: begin
          v = (res >> (8 * off)) % 256;
          e.data = (f3 == 0 && v >= 128) ? v + 32'hFFFF_FF00 : v;
        end
        1, 5: begin
          v = (res >> (16 * (off / 2))) % 65536;
          e.data  = (f3 == 1 && v >= 32768) ? v + 32'hFFFF_0000 : v;
          e.fault = (off % 2) != 0;
        end
        2: e.fault = (off != 0);
        default: e.fault = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = '0; m_wb_en = 0; m_wb_rd = 0; m_wb_data = 0; m_exc = 0; m_retired = 0;
  endtask

  // One clock: check in_ready, advance the model with the current inputs,
  // take the edge, then compare every registered output.
  task automatic tick();
    bit       deq, enq;
    m_entry_t e;
    chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
    deq = (mq.size() != 0) && wb_ready;
    enq = in_valid && (mq.size() < 2);
    m_wb_en = 0; m_exc = 0;
    if (deq) begin
      e = mq.pop_front();
      m_wb_rd = e.rd; m_wb_data = e.data; m_exc = e.fault;
      m_wb_en = (e.rd != 0) && !e.fault;
      m_busy[e.rd] = 1'b0;
    end
    if (enq) mq.push_back(fmt(in_rd, in_result, in_is_load, in_funct3, in_addr_lo));
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (m_wb_en) m_retired++;
    @(posedge clk);
    #1;
    chk("wb_en",   {31'b0, wb_en}, {31'b0, m_wb_en});
    chk("wb_rd",   {27'b0, wb_rd}, m_wb_rd);
    chk("wb_data", wb_data, m_wb_data);
    chk("exc",     {31'b0, exc}, {31'b0, m_exc});
    chk("busy",    busy, m_busy);
    chk("retired", retired, m_retired);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] res, input logic ld,
                      input logic [2:0] f3, input logic [1:0] off);
    in_valid = 1'b1; in_rd = rd; in_result = res;
    in_is_load = ld; in_funct3 = f3; in_addr_lo = off;
  endtask

  logic [31:0] ld_word;
  logic [2:0]  ld_f3  [5];
  logic [1:0]  ld_off [5];
  logic [31:0] ld_exp [5];

  initial begin
    rst_n = 1'b0; issue_valid = 0; issue_rd = 0; in_valid = 0; in_rd = 0;
    in_result = 0; in_is_load = 0; in_funct3 = 0; in_addr_lo = 0; wb_ready = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_en",   {31'b0, wb_en}, 32'd0);
    chk("rst_wb_rd",   {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc",     {31'b0, exc}, 32'd0);
    chk("rst_busy",    busy, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic ALU writeback to x5
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_valid = 0;
    chk("busy5_set", {31'b0, busy[5]}, 32'd1);
    wb_ready = 1;
    push(5, 32'h1234_5678, 0, 3'b000, 2'd0);
    tick();
    in_valid = 0;
    tick();
    chk("basic_wb_en",   {31'b0, wb_en}, 32'd1);
    chk("basic_wb_rd",   {27'b0, wb_rd}, 32'd5);
    chk("basic_wb_data", wb_data, 32'h1234_5678);
    chk("basic_busy5",   {31'b0, busy[5]}, 32'd0);
    chk("basic_retired", retired, 32'd1);

    // Load formatting of 0x80FF7F01
    ld_word = 32'h80FF_7F01;
    ld_f3[0] = 3'b000; ld_off[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
    ld_f3[1] = 3'b100; ld_off[1] = 2'd1; ld_exp[1] = 32'h0000_007F;
    ld_f3[2] = 3'b001; ld_off[2] = 2'd2; ld_exp[2] = 32'hFFFF_80FF;
    ld_f3[3] = 3'b101; ld_off[3] = 2'd0; ld_exp[3] = 32'h0000_7F01;
    ld_f3[4] = 3'b010; ld_off[4] = 2'd0; ld_exp[4] = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      push(3, ld_word, 1, ld_f3[i], ld_off[i]);
      tick();
      in_valid = 0;
      tick();
      chk($sformatf("load%0d_data", i), wb_data, ld_exp[i]);
      chk($sformatf("load%0d_en", i), {31'b0, wb_en}, 32'd1);
    end

    // Faulting loads to x7: misaligned LW and reserved funct3 011
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1; issue_rd = 7;
      tick();
      issue_valid = 0;
      push(7, 32'hCAFE_F00D, 1, (i == 0) ? 3'b010 : 3'b011, (i == 0) ? 2'd2 : 2'd0);
      tick();
      in_valid = 0;
      tick();
      chk($sformatf("fault%0d_exc", i),     {31'b0, exc}, 32'd1);
      chk($sformatf("fault%0d_wb_en", i),   {31'b0, wb_en}, 32'd0);
      chk($sformatf("fault%0d_busy7", i),   {31'b0, busy[7]}, 32'd0);
      chk($sformatf("fault%0d_retired", i), retired, 32'd6);
      tick();
      chk($sformatf("fault%0d_exc_pulse", i), {31'b0, exc}, 32'd0);
    end

    // Backpressure: fill with wb_ready low, third result held
    wb_ready = 0;
    push(10, 32'hA, 0, 3'b000, 2'd0); tick();
    push(11, 32'hB, 0, 3'b000, 2'd0); tick();
    push(12, 32'hC, 0, 3'b000, 2'd0);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("full_hold_in_ready", {31'b0, in_ready}, 32'd0);
    wb_ready = 1;
    tick();
    chk("drain0_rd", {27'b0, wb_rd}, 32'd10);
    chk("drain0_en", {31'b0, wb_en}, 32'd1);
    chk("drain0_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 0;
    chk("drain1_rd", {27'b0, wb_rd}, 32'd11);
    tick();
    chk("drain2_rd",   {27'b0, wb_rd}, 32'd12);
    chk("drain2_data", wb_data, 32'hC);
    chk("drain_retired", retired, 32'd9);

    // x0 is never written or busy
    issue_valid = 1; issue_rd = 0;
    push(0, 32'hDEAD, 0, 3'b000, 2'd0);
    tick();
    issue_valid = 0; in_valid = 0;
    tick();
    chk("x0_wb_en",  {31'b0, wb_en}, 32'd0);
    chk("x0_busy0",  {31'b0, busy[0]}, 32'd0);
    chk("x0_retired", retired, 32'd9);

    // Issue to x9 on the same edge an x9 entry retires: set wins
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    push(9, 32'h99, 0, 3'b000, 2'd0);
    tick();
    in_valid = 0;
    issue_valid = 1; issue_rd = 9;
    tick();
    issue_valid = 0;
    chk("x9_wb_en",  {31'b0, wb_en}, 32'd1);
    chk("x9_busy9",  {31'b0, busy[9]}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      wb_ready    = ($urandom_range(0, 3) != 0);
      push(5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      in_valid    = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 0; issue_valid = 0; wb_ready = 1;
    repeat (3) tick();

    // Asynchronous reset with two entries queued and busy bits pending
    wb_ready = 0;
    issue_valid = 1; issue_rd = 4;
    push(4, 32'h44, 0, 3'b000, 2'd0); tick();
    issue_rd = 6;
    push(6, 32'h66, 0, 3'b000, 2'd0); tick();
    issue_valid = 0; in_valid = 0;
    chk("pre_rst_busy_nz", {31'b0, busy != 32'd0}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_wb_en",   {31'b0, wb_en}, 32'd0);
    chk("arst_exc",     {31'b0, exc}, 32'd0);
    chk("arst_busy",    busy, 32'd0);
    chk("arst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_ready = 1;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_no_wb%0d", i), {31'b0, wb_en}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_wb.md
Name: riscv_wb

Overview:
Writeback stage and register scoreboard for the RISC-V pipeline. It is the write side of the register file that the decode stage reads. It accepts executed or loaded results over a valid/ready handshake and formats load data per funct3. Results are buffered in a 2-entry FIFO and drive the register-file write port. A per-register busy bitmap, set when decode issues and cleared at retirement, lets decode stall on RAW hazards.

Parameters:
XLEN, 32, datapath and register width
REGA, 5, register address width (32 registers)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  decode issued an instruction that writes issue_rd
issue_rd  input  REGA  destination of the issued instruction
in_valid  input  1  result available from execute/memory
in_ready  output  1  stage can accept a result
in_rd  input  REGA  destination register
in_result  input  XLEN  ALU result or raw load word
in_is_load  input  1  in_result is a load word needing formatting
in_funct3  input  3  load width/sign code
in_addr_lo  input  2  load byte offset (address[1:0])
wb_ready  input  1  register file accepts a write this cycle
wb_en  output  1  register-file write strobe (registered)
wb_rd  output  REGA  write address (registered)
wb_data  output  XLEN  write data (registered)
exc  output  1  one-cycle pulse: retired entry faulted
busy  output  32  scoreboard bitmap, bit i = write to xi pending
retired  output  XLEN  count of committed register writes

Behaviour:
- Reset (rst_n low, async): FIFO empty, wb_en=0, wb_rd=0, wb_data=0, exc=0, busy=0, retired=0. in_ready=1 as soon as reset deasserts. Reset mid-operation discards all buffered entries and pending busy bits.
- FIFO: depth 2, with write pointer, read pointer and count.
  - in_ready = (count != 2). It is combinational from count only, with no pass-through when full.
  - Enqueue when in_valid && in_ready.
  - Dequeue when count != 0 && wb_ready.
  - Simultaneous enqueue and dequeue leaves count unchanged. Pointers wrap modulo 2.
- Formatting at enqueue (stored value, fault flag):
  - Non-load: data = in_result, no fault.
  - 000 LB: byte in_result[8*addr_lo +: 8], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH / 101 LHU: halfword in_result[16*addr_lo[1] +: 16], sign/zero-extended. Fault if addr_lo[0]=1.
  - 010 LW: data = in_result. Fault if addr_lo != 0.
  - Any other funct3 with in_is_load: fault.
- Retire, on the dequeue edge:
  - wb_rd <= entry rd and wb_data <= entry data.
  - wb_en <= 1 only if entry rd != 0 and no fault.
  - exc <= entry fault.
  - If no dequeue this edge: wb_en <= 0 and exc <= 0; wb_rd and wb_data hold.
- Latency: a result accepted at edge N with the FIFO empty and wb_ready high gives wb_en high in the cycle after edge N+1 (2 edges).
- x0: never written (wb_en stays 0). busy[0] is constant 0.
- Scoreboard:
  - Set busy[issue_rd] on issue_valid when issue_rd != 0.
  - Clear busy[rd] on the dequeue edge of the entry with that rd. Faulted entries also clear, to avoid deadlock.
  - Same edge, same register, set and clear: set wins.
  - Issuing to an already-busy rd leaves it set. There is no per-register count; decode must stall issue while busy[rd] or busy[rs] is set.
  - busy clears on the same edge that wb_en rises.
- retired increments by 1 on every edge where wb_en is loaded with 1. It wraps at 2^XLEN.

Test Plan:
- Reset, then issue rd=5 and push {rd=5, result=0x1234_5678, non-load} with wb_ready=1 → busy[5]=1 after issue. Two edges after accept: wb_en=1, wb_rd=5, wb_data=0x12345678. busy[5]=0 and retired=1 in the same cycle.
- Loads of word 0x80FF_7F01: LB off=3 → 0xFFFFFF80; LBU off=1 → 0x0000007F; LH off=2 → 0xFFFF80FF; LHU off=0 → 0x00007F01; LW off=0 → 0x80FF7F01.
- Misaligned LW off=2 and funct3=011 load (rd=7, issued) → each retires with exc=1 for one cycle, wb_en=0, busy[7] cleared, retired unchanged.
- Hold wb_ready=0 and push 3 results → in_ready=0 after 2 accepts and the third is held. Release wb_ready → FIFO-order writebacks on consecutive cycles. With in_valid and wb_ready both high while full, in_ready stays 0 until count drops.
- Result for rd=0 with in_result=0xDEAD → wb_en stays 0 and busy[0] stays 0. Issue rd=9 on the same edge an rd=9 entry retires → busy[9] remains 1.
- Assert rst_n=0 asynchronously with 2 entries queued and busy nonzero → wb_en, exc, busy and retired are 0 immediately; no writeback occurs after release.
